// File: rtl/spram_stream_fifo.sv
// Streaming FIFO controller in front of a single-port SPRAM (active-low
// CEN/WEN, 1-cycle registered read). Input words are written to the SPRAM.
// Words are read back into a 2-entry output buffer that hides the read
// latency. The one memory port is shared: refilling an empty output path
// wins over a write, a write wins over a top-up read, and a top-up read
// happens otherwise.
module spram_stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [DATA_WIDTH-1:0]   IN_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [DATA_WIDTH-1:0]   OUT_DATA,
    output logic [ADDR_WIDTH+1:0]   LEVEL,
    output logic                    MEM_CEN,
    output logic                    MEM_WEN,
    output logic [ADDR_WIDTH-1:0]   MEM_A,
    output logic [DATA_WIDTH-1:0]   MEM_D,
    input  logic [DATA_WIDTH-1:0]   MEM_Q
);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] ob0, ob1;
    logic [1:0]            ob_cnt;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [DATA_WIDTH-1:0] mem_d_q;

    logic [1:0] out_occ;
    logic       rd_req, full, rd_urgent;
    logic       do_rd, do_wr;
    logic       push, pop;

    // Port arbitration from registered state; at most one SPRAM op per cycle.
    always_comb begin
        out_occ   = ob_cnt + {1'b0, rd_pend};
        rd_req    = (mem_count != '0) && (out_occ < 2'd2);
        full      = (mem_count == FULL_CNT);
        rd_urgent = rd_req && (out_occ == 2'd0);
        IN_READY  = !RST && !full && !rd_urgent;
        do_wr     = IN_READY && IN_VALID;
        do_rd     = !RST && rd_req && !do_wr;
        MEM_CEN   = !(do_rd || do_wr);
        MEM_WEN   = !do_wr;
        MEM_A     = do_rd ? rd_ptr : (do_wr ? wr_ptr : mem_a_q);
        MEM_D     = do_wr ? IN_DATA : mem_d_q;
        push      = rd_pend;
        pop       = (ob_cnt != 2'd0) && OUT_READY;
        OUT_VALID = (ob_cnt != 2'd0);
        OUT_DATA  = ob0;
        LEVEL     = (ADDR_WIDTH+2)'(mem_count) + (ADDR_WIDTH+2)'(out_occ);
    end

    // Memory-side state: pointers, resident count, held address/data bus.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_pend   <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
        end else begin
            rd_pend <= do_rd;
            if (do_wr) begin
                wr_ptr    <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
                mem_count <= mem_count + 1'b1;
                mem_a_q   <= wr_ptr;
                mem_d_q   <= IN_DATA;
            end else if (do_rd) begin
                rd_ptr    <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
                mem_count <= mem_count - 1'b1;
                mem_a_q   <= rd_ptr;
            end
        end
    end

    // Output buffer: push read data one cycle after the read, pop on handshake.
    // Push into a full buffer cannot occur because reads stop at out_occ==2.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ob0    <= '0;
            ob1    <= '0;
            ob_cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) ob0 <= MEM_Q;
                    else                ob1 <= MEM_Q;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    ob0    <= ob1;
                    ob_cnt <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob0 <= MEM_Q;
                    end else begin
                        ob0 <= ob1;
                        ob1 <= MEM_Q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_stream_fifo.sv
// Bench for spram_stream_fifo with DEPTH=4 and a behavioural SPRAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge, where a scoreboard queue tracks accepted words.
module tb_spram_stream_fifo;

    localparam int DW = 32;
    localparam int DP = 4;
    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [DW-1:0] IN_DATA, OUT_DATA, MEM_D, MEM_Q;
    logic [AW+1:0] LEVEL;
    logic          MEM_CEN, MEM_WEN;
    logic [AW-1:0] MEM_A;

    spram_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .LEVEL(LEVEL),
        .MEM_CEN(MEM_CEN), .MEM_WEN(MEM_WEN), .MEM_A(MEM_A),
        .MEM_D(MEM_D), .MEM_Q(MEM_Q)
    );

    always #5 CLK = ~CLK;

    // Behavioural SPRAM: registered read, write when CEN and WEN both low.
    logic [DW-1:0] mem [DP];
    always @(posedge CLK) begin
        if (!MEM_CEN) begin
            if (!MEM_WEN) mem[MEM_A] <= MEM_D;
            else          MEM_Q <= mem[MEM_A];
        end
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] sbq[$];
    int model_level, wr_addr, rd_addr;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    logic last_acc, last_pop;
    logic s_irdy, s_ov, s_cen, s_wen;
    logic [AW+1:0] s_level;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_od;

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_irdy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [AW+1:0] e_lvl;
        logic          e_cen;
        logic          e_wen;
        logic [AW-1:0] e_a;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_reset();
        sbq.delete();
        model_level = 0;
        wr_addr = 0;
        rd_addr = 0;
        last_a = '0;
        last_d = '0;
    endtask

    // One clock: sample and check at the falling edge, then advance past the rising edge.
    task automatic step();
        logic rd;
        logic [DW-1:0] e;
        @(negedge CLK);
        s_irdy = IN_READY; s_ov = OUT_VALID; s_cen = MEM_CEN; s_wen = MEM_WEN;
        s_level = LEVEL; s_a = MEM_A; s_od = OUT_DATA;
        last_acc = IN_VALID && IN_READY;
        last_pop = OUT_VALID && OUT_READY;
        rd = !MEM_CEN && MEM_WEN;
        chk("level", 64'(LEVEL), 64'(model_level));
        if (!MEM_CEN && !MEM_WEN) chk("wr_has_handshake", 64'(last_acc), 64'd1);
        if (last_acc) begin
            chk("wr_op", {62'd0, MEM_CEN, MEM_WEN}, 64'd0);
            chk("wr_addr", 64'(MEM_A), 64'(wr_addr));
            chk("wr_data", 64'(MEM_D), 64'(IN_DATA));
            sbq.push_back(IN_DATA);
            wr_addr = (wr_addr + 1) % DP;
        end
        if (rd) begin
            chk("rd_addr", 64'(MEM_A), 64'(rd_addr));
            rd_addr = (rd_addr + 1) % DP;
        end
        if (MEM_CEN)
            chk("idle_hold", {29'd0, MEM_WEN, MEM_A, MEM_D}, {29'd0, 1'b1, last_a, last_d});
        else begin
            last_a = MEM_A;
            if (!MEM_WEN) last_d = MEM_D;
        end
        if (last_pop) begin
            if (sbq.size() == 0) chk("pop_underflow", 64'd1, 64'd0);
            else begin
                e = sbq.pop_front();
                chk("out_data", 64'(OUT_DATA), 64'(e));
            end
        end
        model_level = model_level + int'(last_acc) - int'(last_pop);
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 100 && model_level != 0; i++) step();
        step();
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        chk("drain_ov", 64'(s_ov), 64'd0);
    endtask

    initial begin
        int k, first_rd, first_rdy, popped;
        logic [AW+1:0] lvl_x;

        tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0,          4'd0, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 32'h0,          4'd1, 1'b0, 1'b1, 2'd0};
        tbl[2] = '{1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0,          4'd1, 1'b1, 1'b1, 2'd0};
        tbl[3] = '{1'b0, 32'h0,          1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 4'd1, 1'b1, 1'b1, 2'd0};
        tbl[4] = '{1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0,          4'd0, 1'b1, 1'b1, 2'd0};

        // Power-on reset with input offered: outputs must sit at reset values.
        RST = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'h1234; OUT_READY = 1'b0;
        sb_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("por_irdy", 64'(IN_READY), 64'd0);
        chk("por_cen", 64'(MEM_CEN), 64'd1);
        chk("por_ov", 64'(OUT_VALID), 64'd0);
        chk("por_level", 64'(LEVEL), 64'd0);
        chk("por_od", 64'(OUT_DATA), 64'd0);
        RST = 1'b0; IN_VALID = 1'b0;
        step();

        // Single-word latency, table driven.
        for (int i = 0; i < 5; i++) begin
            IN_VALID = tbl[i].iv; IN_DATA = tbl[i].id; OUT_READY = tbl[i].ordy;
            step();
            chk("t2_irdy", 64'(s_irdy), 64'(tbl[i].e_irdy));
            chk("t2_ov", 64'(s_ov), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk("t2_od", 64'(s_od), 64'(tbl[i].e_od));
            chk("t2_level", 64'(s_level), 64'(tbl[i].e_lvl));
            chk("t2_cen", 64'(s_cen), 64'(tbl[i].e_cen));
            chk("t2_wen", 64'(s_wen), 64'(tbl[i].e_wen));
            chk("t2_a", 64'(s_a), 64'(tbl[i].e_a));
        end

        // Fill with output stalled: 6 of 1..8 accepted.
        OUT_READY = 1'b0;
        k = 1;
        for (int i = 0; i < 20; i++) begin
            IN_VALID = (k <= 8);
            IN_DATA = 32'(k);
            step();
            if (last_acc) k++;
        end
        chk("fill_accepted", 64'(k - 1), 64'd6);
        chk("fill_irdy", 64'(s_irdy), 64'd0);
        chk("fill_level", 64'(s_level), 64'd6);
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        first_rd = -1; first_rdy = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!s_cen && s_wen && first_rd < 0) first_rd = i;
            if (s_irdy && first_rdy < 0) first_rdy = i;
        end
        chk("fill_drain_read_seen", 64'(first_rd >= 0), 64'd1);
        chk("fill_irdy_after_read", 64'(first_rdy > first_rd), 64'd1);
        drain();

        // Priority: input held high, output always ready.
        OUT_READY = 1'b1;
        k = 0; first_rd = 0;
        for (int i = 0; i < 30; i++) begin
            IN_VALID = 1'b1;
            IN_DATA = 32'h4000_0000 + 32'(k);
            step();
            if (last_acc) k++;
            if (!s_cen && s_wen) begin
                first_rd++;
                chk("prio_rd_blocks_in", 64'(s_irdy), 64'd0);
            end
        end
        chk("prio_reads_seen", 64'(first_rd > 0), 64'd1);
        drain();

        // Simultaneous push and pop with a full output buffer.
        OUT_READY = 1'b0;
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            IN_VALID = 1'b1;
            IN_DATA = 32'h600 + 32'(k);
            step();
            if (last_acc) k++;
        end
        IN_VALID = 1'b0;
        repeat (6) step();
        chk("pp_pre_level", 64'(s_level), 64'd3);
        chk("pp_pre_ov", 64'(s_ov), 64'd1);
        IN_VALID = 1'b1; IN_DATA = 32'h604; OUT_READY = 1'b1;
        step();
        chk("pp_write", {62'd0, s_cen, s_wen}, 64'd0);
        chk("pp_hs", {62'd0, last_acc, last_pop}, 64'd3);
        lvl_x = s_level;
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        step();
        chk("pp_level_same", 64'(s_level), 64'(lvl_x));
        chk("pp_refill_read", {62'd0, s_cen, s_wen}, 64'd1);
        drain();

        // Wrap: stream 0..19 under random valid/ready.
        k = 0; popped = 0;
        for (int i = 0; i < 2000 && popped < 20; i++) begin
            IN_VALID = (k < 20) && ($urandom_range(2) != 0);
            IN_DATA = 32'(k);
            OUT_READY = $urandom_range(1);
            step();
            if (last_acc) k++;
            if (last_pop) popped++;
            if (s_level > 4'd6) chk("wrap_level_max", 64'(s_level), 64'd6);
        end
        chk("wrap_popped", 64'(popped), 64'd20);
        chk("wrap_sb_empty", 64'(sbq.size()), 64'd0);

        // Reset mid-stream, then the first word goes to address 0.
        OUT_READY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            IN_VALID = 1'b1;
            IN_DATA = 32'h7700 + 32'(i);
            step();
        end
        RST = 1'b1;
        #1;
        chk("mid_rst_ov", 64'(OUT_VALID), 64'd0);
        chk("mid_rst_irdy", 64'(IN_READY), 64'd0);
        chk("mid_rst_cen", 64'(MEM_CEN), 64'd1);
        chk("mid_rst_level", 64'(LEVEL), 64'd0);
        chk("mid_rst_od", 64'(OUT_DATA), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sb_reset();
        IN_DATA = 32'hBEEF_0000; OUT_READY = 1'b1;
        step();
        chk("post_rst_acc", 64'(last_acc), 64'd1);
        chk("post_rst_addr", 64'(s_a), 64'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
